// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer and its per-output elastic slot.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_e;

  localparam int unsigned PERF_CNT_W = 32;

  // Select width: at least one bit even for a single output.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// Two-entry elastic slot: registered valid/data towards the consumer, full flag towards the router.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  output logic             full,
  output logic             valid,
  output logic [DATAW-1:0] data,
  input  logic             ready
);

  slot_state_e      state_q, state_d;
  logic [DATAW-1:0] head_q, head_d;
  logic [DATAW-1:0] spare_q, spare_d;
  logic             pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers carry no reset; they are only observed while valid.
  always_ff @(posedge clk) begin
    head_q  <= head_d;
    spare_q <= spare_d;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    spare_d = spare_q;
    pop     = (state_q != EMPTY) && ready;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = push_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          state_d = TWO;
          spare_d = push_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = spare_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign full  = (state_q == TWO);
  assign valid = (state_q != EMPTY);
  assign data  = head_q;

endmodule

// File: rtl/stream_demux.sv
// Steers one valid/ready stream to NUM_OUTS outputs by sel_in, optionally through per-output slots.
// Optional stall counters per output when STREAM_DEMUX_PERF_EN is defined.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned NUM_OUTS = 2,
  parameter  int unsigned DATAW    = 1,
  parameter  int unsigned BUFFERED = 1,
  localparam int unsigned SELW     = sel_width(NUM_OUTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  input  logic [SELW-1:0]                sel_in,
  input  logic [DATAW-1:0]               data_in,
  output logic                           ready_in,
  output logic [NUM_OUTS-1:0]            valid_out,
  output logic [NUM_OUTS-1:0][DATAW-1:0] data_out,
  input  logic [NUM_OUTS-1:0]            ready_out
`ifdef STREAM_DEMUX_PERF_EN
  ,
  output logic [NUM_OUTS-1:0][PERF_CNT_W-1:0] perf_stalls_out
`endif
);

  logic                sel_ok_c;
  logic [NUM_OUTS-1:0] sel_hit_c;

  // A single output ignores sel_in entirely.
  assign sel_ok_c = (NUM_OUTS == 1) || (32'(sel_in) < NUM_OUTS);

  always_comb begin
    sel_hit_c = '0;
    for (int unsigned i = 0; i < NUM_OUTS; i++) begin
      sel_hit_c[i] = (NUM_OUTS == 1) || (sel_in == SELW'(i));
    end
  end

  if (NUM_OUTS == 1) begin : g_wire
    assign valid_out   = valid_in;
    assign data_out[0] = data_in;
    assign ready_in    = ready_out[0];
  end else if (BUFFERED == 0) begin : g_comb
    assign valid_out = {NUM_OUTS{valid_in}} & sel_hit_c;
    assign data_out  = {NUM_OUTS{data_in}};
    assign ready_in  = sel_ok_c ? ready_out[sel_in] : 1'b1;
  end else begin : g_buf
    logic [NUM_OUTS-1:0] full_c;
    logic [NUM_OUTS-1:0] push_c;

    // Backpressure comes from slot occupancy only, never from ready_out.
    assign ready_in = sel_ok_c ? !full_c[sel_in] : 1'b1;
    assign push_c   = {NUM_OUTS{valid_in}} & sel_hit_c & ~full_c;

    for (genvar i = 0; i < NUM_OUTS; i++) begin : g_slot
      stream_demux_slot #(
        .DATAW(DATAW)
      ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .push     (push_c[i]),
        .push_data(data_in),
        .full     (full_c[i]),
        .valid    (valid_out[i]),
        .data     (data_out[i]),
        .ready    (ready_out[i])
      );
    end
  end

`ifdef STREAM_DEMUX_PERF_EN
  logic [NUM_OUTS-1:0][PERF_CNT_W-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int unsigned i = 0; i < NUM_OUTS; i++) begin
      if (valid_in && sel_hit_c[i] && !ready_in) begin
        perf_d[i] = perf_q[i] + PERF_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stalls_out = perf_q;
`endif

`ifndef SYNTHESIS
  sel_in_range_a: assert property (@(posedge clk) disable iff (reset) valid_in |-> sel_ok_c);
`endif

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Downstream counterpart of the stream arbiter: takes one valid/ready stream carrying a destination select and steers each beat to one of NUM_OUTS output streams.
- Used to route merged-channel responses back to their requesters, e.g. memory responses to the originating core or port.
- Each output has an optional 2-entry elastic slot. A stalled consumer then backs up only beats addressed to it, and all output signals are registered.

Parameters:
- NUM_OUTS, 2, number of output streams (>=1)
- DATAW, 1, payload width in bits
- BUFFERED, 1. 1: per-output 2-entry slot, latency 1. 0: combinational steering, latency 0
- SELW, derived = max(1, clog2(NUM_OUTS)), select width (localparam, not overridable)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- valid_in  in  1  input beat valid
- sel_in  in  SELW  destination index of input beat
- data_in  in  DATAW  input payload
- ready_in  out  1  input accepted this cycle when high with valid_in
- valid_out  out  NUM_OUTS  per-output valid
- data_out  out  NUM_OUTS x DATAW  per-output payload
- ready_out  in  NUM_OUTS  per-output consumer ready

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, named reset.
- Handshake:
  - Input transfer when valid_in && ready_in.
  - Output i transfer when valid_out[i] && ready_out[i].
  - valid_out[i] never drops without a transfer; data_out[i] is stable while valid_out[i] && !ready_out[i].
- NUM_OUTS==1: pure wire-through (valid_out=valid_in, data_out=data_in, ready_in=ready_out), sel_in ignored, BUFFERED ignored.
- BUFFERED=0, combinational:
  - valid_out[i] = valid_in && (sel_in==i); data_out[i] = data_in for all i.
  - ready_in = ready_out[sel_in].
  - No state; latency 0.
- BUFFERED=1: one slot per output with state EMPTY, ONE or TWO, plus 2 data registers (head, spare).
  - ready_in = (state[sel_in] != TWO). It depends only on registered state and sel_in, never on ready_out.
  - EMPTY: push -> ONE (head <= data_in).
  - ONE: push and pop -> ONE (head <= data_in). Push only -> TWO (spare <= data_in). Pop only -> EMPTY.
  - TWO: no push possible. Pop -> ONE (head <= spare).
  - valid_out[i] = (state[i] != EMPTY); data_out[i] = head[i].
  - Latency 1 cycle input->output. Full throughput of 1 beat/cycle per output when the consumer keeps ready_out high.
  - Per-output ordering is FIFO. There is no ordering guarantee across outputs.
  - A push and a pop on the same output in the same cycle are both honoured. Pushes to output j proceed while output i is stalled in TWO.
- Out-of-range select (sel_in >= NUM_OUTS, only possible when NUM_OUTS is not a power of two):
  - This is a protocol violation and fires a simulation assertion.
  - Hardware behaviour: ready_in=1, beat discarded, no state change.
- Reset:
  - All slots go to EMPTY and valid_out=0 immediately (asynchronously); ready_in=1 once reset is released.
  - Data registers are not reset; data_out is don't-care while valid_out is 0.
  - Reset mid-operation drops all buffered beats.

Optional Feature:
- Macro: STREAM_DEMUX_PERF_EN.
- Defined:
  - Adds output port perf_stalls_out, NUM_OUTS x 32.
  - Counter i increments each cycle valid_in && sel_in==i && !ready_in.
  - Counters wrap modulo 2^32 and reset asynchronously to 0.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - Slot-state enum: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Select-width helper function max(1, clog2(n)).
  - Perf counter width constant 32.
- One natural sub-module: stream_demux_slot. It is the 2-entry elastic slot with push/data/full on the input side and valid/data/ready on the output side, instantiated NUM_OUTS times under BUFFERED=1.

Test Plan:
- Single beat (NUM_OUTS=4, DATAW=8, BUFFERED=1): valid_in, sel_in=2, data_in=0xA5, ready_out=4'b1111 -> valid_out=4'b0100, data_out[2]=0xA5 next cycle, gone the cycle after.
- Stall fill, consumer 1 held not ready: push 0x11, 0x22 to output 1 -> state TWO, ready_in=0 for sel_in=1. A push 0x33 to output 3 in the same cycle is accepted. Then raise ready_out[1] -> 0x11 then 0x22 emerge in order, and ready_in returns to 1 one cycle after the first pop.
- Streaming: 16 back-to-back beats 0..15 to output 0 with ready_out[0]=1 -> 16 consecutive output cycles, values 0..15, no bubbles.
- Simultaneous push and pop: slot in ONE holding 0x40, push 0x41 with ready_out=1 -> 0x40 out this cycle, 0x41 valid next cycle, slot stays ONE.
- Reset mid-operation: two slots in TWO, assert reset asynchronously between clock edges -> valid_out=0 immediately; after release ready_in=1 and no stale beats appear.
- BUFFERED=0, and STREAM_DEMUX_PERF_EN defined:
  - sel_in=1, ready_out[1]=0 for 5 cycles -> valid_out[1]=1 combinationally, ready_in=0, perf_stalls_out[1]=5.
  - With NUM_OUTS=3, sel_in=3 -> beat dropped, assertion fires.
